// File: rtl/alu_pkg.sv
// Shared types and constants for the arbitrated ALU front end.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU: ADD/SUB/AND/OR with {N,Z,C,V} flags.
// Zero latency, no flow control; the caller registers inputs and outputs.
module alu
  import alu_pkg::*;
#(
  parameter int Bits = 5
) (
  input  logic [Bits-1:0] InA,
  input  logic [Bits-1:0] InB,
  input  op_e             Control,
  output logic [Bits-1:0] Result,
  output logic [3:0]      Flags
);

  logic [Bits-1:0] b_eff;
  logic [Bits:0]   sum;
  logic            is_sub;
  logic            is_arith;

  always_comb begin
    is_sub   = (Control == OP_SUB);
    is_arith = (Control == OP_ADD) || is_sub;
    // SUB runs through the same adder as A + ~B + 1 so carry means A >= B.
    b_eff    = is_sub ? ~InB : InB;
    sum      = {1'b0, InA} + {1'b0, b_eff} + {{Bits{1'b0}}, is_sub};

    case (Control)
      OP_AND:  Result = InA & InB;
      OP_OR:   Result = InA | InB;
      default: Result = sum[Bits-1:0];
    endcase

    Flags         = 4'b0000;
    Flags[FLAG_N] = Result[Bits-1];
    Flags[FLAG_Z] = ~|Result;
    Flags[FLAG_C] = is_arith & sum[Bits];
    Flags[FLAG_V] = is_arith & (InA[Bits-1] == b_eff[Bits-1]) &
                    (Result[Bits-1] != InA[Bits-1]);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin two-requester front end to one ALU; accept-to-response 2 cycles.
// One op in flight; rsp_ready low holds RESP and keeps both req_ready at 0.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int Bits = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [Bits-1:0] req0_a,
  input  logic [Bits-1:0] req0_b,
  input  logic [1:0]      req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [Bits-1:0] req1_a,
  input  logic [Bits-1:0] req1_b,
  input  logic [1:0]      req1_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [Bits-1:0] rsp_result,
  output logic [3:0]      rsp_flags
);

  arb_state_e      state_q;
  logic            last_grant_q;
  logic [Bits-1:0] a_q, b_q;
  op_e             op_q;
  logic            id_q;
  logic            rsp_valid_q;
  logic            rsp_id_q;
  logic [Bits-1:0] rsp_result_q;
  logic [3:0]      rsp_flags_q;

  logic            grant_d;
  logic [Bits-1:0] a_d, b_d;
  op_e             op_d;
  logic            hs;
  logic [Bits-1:0] alu_result;
  logic [3:0]      alu_flags;

  // Only registered state feeds req_ready, keeping rsp_ready off this path.
  always_comb begin
    grant_d    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready = (state_q == IDLE) && req0_valid && !grant_d;
    req1_ready = (state_q == IDLE) && req1_valid && grant_d;
    hs         = req0_ready || req1_ready;
    a_d        = grant_d ? req1_a : req0_a;
    b_d        = grant_d ? req1_b : req0_b;
    op_d       = op_e'(grant_d ? req1_op : req0_op);
  end

  alu #(
    .Bits(Bits)
  ) u_alu (
    .InA    (a_q),
    .InB    (b_q),
    .Control(op_q),
    .Result (alu_result),
    .Flags  (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_ADD;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'b0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= grant_d;
            last_grant_q <= grant_d;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_flags_q  <= alu_flags;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus random bench for alu_arbiter (Bits = 5) against an arithmetic model.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [4:0] rsp_result;
  logic [3:0] rsp_flags;

  int errors = 0;
  int checks = 0;
  int lg_model = 1;

  alu_arbiter #(.Bits(5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {N,Z,C,V,result} from plain integer arithmetic.
  function automatic logic [8:0] model(input logic [4:0] a, input logic [4:0] b, input logic [1:0] op);
    int ua, ub, sa, sb, full, s, res;
    bit c, v;
    ua = int'(a); ub = int'(b);
    sa = (ua >= 16) ? ua - 32 : ua;
    sb = (ub >= 16) ? ub - 32 : ub;
    c = 0; v = 0;
    case (op)
      2'b00: begin full = ua + ub; res = full % 32; c = (full >= 32);
                   s = sa + sb; v = (s > 15) || (s < -16); end
      2'b01: begin res = (ua - ub + 32) % 32; c = (ua >= ub);
                   s = sa - sb; v = (s > 15) || (s < -16); end
      2'b10:   res = ua & ub;
      default: res = ua | ub;
    endcase
    return {(res >= 16), (res == 0), c, v, 5'(res)};
  endfunction

  // Presents both requesters (valids held throughout), checks grant and response.
  task automatic do_op(input bit v0, input bit v1,
                       input logic [4:0] a0, input logic [4:0] b0, input logic [1:0] op0,
                       input logic [4:0] a1, input logic [4:0] b1, input logic [1:0] op1,
                       input int stall, output int won,
                       output logic [4:0] res, output logic [3:0] flg);
    int ew, n;
    logic [8:0] exp;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp_ready = (stall == 0);
    won = -1; res = 'x; flg = 'x;
    #1;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) begin
      chk("hs_timeout", 0, 1);
      return;
    end
    ew = (v0 && v1) ? (lg_model == 0 ? 1 : 0) : (v1 ? 1 : 0);
    chk("grant", {req1_ready, req0_ready}, (ew == 1) ? 2'b10 : 2'b01);
    won = req1_ready ? 1 : 0;
    exp = (ew == 1) ? model(a1, b1, op1) : model(a0, b0, op0);
    lg_model = ew;
    @(posedge clk); #1;
    chk("exec_valid", rsp_valid, 0);
    chk("exec_ready", {req1_ready, req0_ready}, 0);
    @(posedge clk); #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, ew);
    chk("rsp_result", rsp_result, exp[4:0]);
    chk("rsp_flags", rsp_flags, exp[8:5]);
    res = rsp_result; flg = rsp_flags;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", {rsp_id, rsp_flags, rsp_result}, {ew[0], exp[8:5], exp[4:0]});
      chk("hold_ready", {req1_ready, req0_ready}, 0);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    chk("rsp_drop", rsp_valid, 0);
  endtask

  initial begin
    int won;
    int n;
    logic [4:0] res;
    logic [3:0] flg;
    logic [1:0] v;

    rst = 1; rsp_ready = 1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_flags", rsp_flags, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    rst = 0;
    @(posedge clk); #1;

    do_op(1, 0, 5'd7, 5'd9, 2'b00, 5'd0, 5'd0, 2'b00, 0, won, res, flg);
    chk("add_id", won, 0);
    chk("add_res", res, 5'b10000);
    chk("add_flg", flg, 4'b1001);

    do_op(0, 1, 5'd0, 5'd0, 2'b00, 5'd5, 5'd5, 2'b01, 0, won, res, flg);
    chk("sub_id", won, 1);
    chk("sub_res", res, 5'd0);
    chk("sub_flg", flg, 4'b0110);

    do_op(1, 0, 5'h1F, 5'h0A, 2'b10, 5'd0, 5'd0, 2'b00, 0, won, res, flg);
    chk("and_res", res, 5'h0A);
    chk("and_flg", flg, 4'b0000);

    do_op(0, 1, 5'd0, 5'd0, 2'b00, 5'h10, 5'h01, 2'b11, 0, won, res, flg);
    chk("or_res", res, 5'h11);
    chk("or_flg", flg, 4'b1000);

    // Tie from a fresh reset: grants must alternate starting with requester 0.
    req0_valid = 0; req1_valid = 0;
    rst = 1; @(posedge clk); #1; rst = 0; lg_model = 1;
    for (int i = 0; i < 6; i++) begin
      do_op(1, 1, 5'(i), 5'(i + 3), 2'b00, 5'(i + 10), 5'(i), 2'b01, 0, won, res, flg);
      chk("rr_seq", won, i % 2);
    end

    do_op(1, 0, 5'd20, 5'd3, 2'b01, 5'd0, 5'd0, 2'b00, 4, won, res, flg);
    chk("bp_accept", req0_ready, 1);

    // Reset while EXEC: the transaction must vanish.
    req0_valid = 0; req1_valid = 1; req1_a = 5'd3; req1_b = 5'd4; req1_op = 2'b00;
    #1;
    n = 0;
    while (!req1_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("mid_hs", req1_ready, 1);
    @(posedge clk); #1;
    rst = 1; req1_valid = 0;
    @(posedge clk); #1;
    rst = 0; lg_model = 1;
    chk("mid_rst_valid", rsp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_no_rsp", rsp_valid, 0);
    end
    do_op(1, 1, 5'd1, 5'd2, 2'b00, 5'd3, 5'd4, 2'b00, 0, won, res, flg);
    chk("mid_tie", won, 0);

    for (int i = 0; i < 40; i++) begin
      v = 2'($urandom_range(1, 3));
      do_op(v[0], v[1], 5'($urandom), 5'($urandom), 2'($urandom),
            5'($urandom), 5'($urandom), 2'($urandom),
            int'($urandom_range(0, 2)), won, res, flg);
    end

    req0_valid = 0; req1_valid = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester front end for the shared combinational ALU. It accepts operation requests over valid/ready handshakes, arbitrates round-robin, registers the operands, executes one operation on a single ALU instance, and returns a registered result plus flags, tagged with the requester ID. It sits between the two datapath clients and the one ALU, so no client drives the ALU directly.

## Interface
- Bits, default 5: operand and result width; must be ≥ 2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  Bits  requester 0 operands.
- req0_op  in  2  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  requester that owns the result.
- rsp_result  out  Bits  ALU result.
- rsp_flags  out  4  {N, Z, C, V} at bits [3:0].

## Operation
- Opcodes: 00 ADD A+B; 01 SUB A−B (A + ~B + 1); 10 AND; 11 OR.
- Flags:
  - N = result[Bits-1].
  - Z = (result == 0).
  - C: ADD gives the carry-out; SUB gives the carry-out of A + ~B + 1, which is 1 when A ≥ B unsigned; AND/OR give 0.
  - V: signed overflow for ADD/SUB (operand signs equal and result sign differs, using ~B for SUB); AND/OR give 0.
- States:
  - IDLE → EXEC on a handshake.
  - EXEC → RESP unconditionally.
  - RESP → IDLE when rsp_ready is high.
- IDLE:
  - req_ready is asserted only toward the granted requester, and only when its valid is high.
  - Handshake occurs when valid && ready.
  - At the handshake, latch a, b, op and the requester ID into operand registers.
- Arbitration:
  - If one requester is valid, it wins.
  - If both are valid, the requester other than last_grant wins.
  - last_grant updates on every handshake.
- EXEC: the ALU sees only the operand registers. At the end of EXEC, rsp_result, rsp_flags and rsp_id are registered.
- RESP:
  - rsp_valid is high.
  - rsp_* outputs stay stable until the cycle in which rsp_ready is high.
  - No new request is accepted in EXEC or RESP; both req_ready outputs are 0.
- A requester may drop valid before it is granted. No request is queued internally.
- Reset:
  - Output values: state IDLE, last_grant = 1 (requester 0 wins the first tie), rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_flags = 0, req0_ready = req1_ready = 0.
  - Reset in EXEC or RESP discards the transaction; no response is produced.

## Timing
- req_ready is combinational from req_valid and the registered state/last_grant. There is no combinational path from rsp_ready to req_ready.
- Handshake at edge N:
  - EXEC occupies cycle N..N+1.
  - rsp_valid is high from edge N+1.
  - Minimum accept-to-response latency is 2 cycles.
- With rsp_ready held high, throughput is one operation per 3 cycles (IDLE, EXEC, RESP).
- Consumer back-pressure extends RESP indefinitely, with outputs held.
- All outputs except req*_ready are registered.

## Structure
- Package alu_pkg:
  - opcode enum: OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11.
  - flag index constants: FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
  - arbiter state enum: IDLE, EXEC, RESP.
- One sub-module, alu, the shared combinational ALU:
  - parameter Bits; ports InA, InB, Control, Result, Flags.
  - Implements exactly the opcode and flag rules above.
  - Instantiated once.
- Arbiter, FSM and registers live in alu_arbiter.

## Test plan
All scenarios use Bits = 5.
- ADD: req0 a = 7, b = 9, op 00, rsp_ready = 1 → two cycles later rsp_id 0, result 5'b10000, flags N=1 Z=0 C=0 V=1.
- SUB to zero: req1 a = 5, b = 5, op 01 → result 0, flags Z=1 C=1 N=0 V=0, rsp_id 1.
- Logic ops:
  - AND: a = 5'h1F, b = 5'h0A, op 10 → result 5'h0A, C=V=0.
  - OR: a = 5'h10, b = 5'h01, op 11 → result 5'h11, N=1.
- Tie, round-robin: both requesters valid continuously with 3 ops each → grants alternate 0,1,0,1,0,1. From reset, the first grant goes to requester 0.
- Back-pressure: rsp_ready low for 4 cycles after rsp_valid rises → rsp_* held stable, both req_ready stay 0, request accepted the cycle after rsp_ready goes high.
- Reset mid-operation: assert rst in EXEC → next cycle state IDLE, rsp_valid = 0, no response for that request; the next tie grants requester 0.
